// File: rtl/apb_spi_master_if.sv
// rtl/apb_spi_master_if.sv - APB bus bundle between a bus master and the SPI master register block
interface apb_spi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_spi_master.sv
// rtl/apb_spi_master.sv - APB register block driving a single-byte mode-0 SPI master engine
module apb_spi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SPI_W  = 8
) (
  input  logic            pclk,
  input  logic            preset_n,
  apb_spi_master_if.slave apb,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso,
  output logic            cs_n,
  output logic            irq
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_TX     = 4'h8;
  localparam logic [3:0] OFF_RX     = 4'hC;
  localparam logic [4:0] LAST_HALF  = 5'(2 * SPI_W);

  state_t           state, state_nxt;
  logic             en, ie, done;
  logic [7:0]       clkdiv, div_q, div_nxt;
  logic [SPI_W-1:0] txdata, rxdata;
  logic [SPI_W-1:0] tx_sh, tx_nxt, rx_sh, rx_nxt;
  logic [8:0]       cnt, cnt_nxt;
  logic [4:0]       half, half_nxt;
  logic             sclk_nxt, cs_n_nxt;

  logic             acc, addr_ok, busy, err, wr;
  logic             ctrl_wr, status_wr, tx_wr;
  logic             en_nxt, start_ok, set_done, rx_load;
  logic [3:0]       off;
  logic [DATA_W-1:0] rdata;
  logic             unused_pwdata;

  assign acc     = apb.psel & apb.penable;
  assign off     = apb.paddr[3:0];
  assign addr_ok = (apb.paddr[ADDR_W-1:4] == '0) && (off[1:0] == 2'b00);
  assign busy    = (state != S_IDLE);
  assign err     = !addr_ok
                 || (apb.pwrite && off == OFF_RX)
                 || (apb.pwrite && off == OFF_TX && busy);
  assign wr        = acc & apb.pwrite & ~err;
  assign ctrl_wr   = wr && (off == OFF_CTRL);
  assign status_wr = wr && (off == OFF_STATUS);
  assign tx_wr     = wr && (off == OFF_TX);

  assign apb.pready  = acc;
  assign apb.pslverr = acc & err;
  assign unused_pwdata = ^apb.pwdata[DATA_W-1:16];

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL: begin
        rdata[0]    = en;
        rdata[2]    = ie;
        rdata[15:8] = clkdiv;
      end
      OFF_STATUS: rdata[1:0]       = {done, busy};
      OFF_TX:     rdata[SPI_W-1:0] = txdata;
      OFF_RX:     rdata[SPI_W-1:0] = rxdata;
      default:    rdata = '0;
    endcase
  end

  assign apb.prdata = (acc && !apb.pwrite && addr_ok) ? rdata : '0;

  // mosi follows the shift register MSB only while a transfer owns the bus
  assign mosi = busy & tx_sh[SPI_W-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 9'd1;
    half_nxt  = half;
    div_nxt   = div_q;
    tx_nxt    = tx_sh;
    rx_nxt    = rx_sh;
    sclk_nxt  = sclk;
    cs_n_nxt  = cs_n;
    start_ok  = 1'b0;
    set_done  = 1'b0;
    rx_load   = 1'b0;
    en_nxt    = ctrl_wr ? apb.pwdata[0] : en;

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (ctrl_wr && apb.pwdata[1] && apb.pwdata[0]) begin
          start_ok  = 1'b1;
          state_nxt = S_SETUP;
          tx_nxt    = txdata;
          div_nxt   = apb.pwdata[15:8];
          cs_n_nxt  = 1'b0;
        end
      end
      // SETUP runs H+1 cycles: the extra cycle is the load cycle after START
      S_SETUP: begin
        if (cnt == {1'b0, div_q} + 9'd1) begin
          state_nxt = S_XFER;
          cnt_nxt   = '0;
          half_nxt  = 5'd1;
          div_nxt   = clkdiv;
          sclk_nxt  = 1'b1;
          rx_nxt    = {rx_sh[SPI_W-2:0], miso};
        end
      end
      S_XFER: begin
        if (cnt == {1'b0, div_q}) begin
          cnt_nxt = '0;
          div_nxt = clkdiv;
          if (half == LAST_HALF) begin
            state_nxt = S_HOLD;
          end else begin
            half_nxt = half + 5'd1;
            if (!half[0]) begin
              sclk_nxt = 1'b1;
              rx_nxt   = {rx_sh[SPI_W-2:0], miso};
            end else begin
              sclk_nxt = 1'b0;
              // no shift on the fall that closes the last bit, so mosi holds it
              if (half != LAST_HALF - 5'd1) tx_nxt = {tx_sh[SPI_W-2:0], 1'b0};
            end
          end
        end
      end
      S_HOLD: begin
        if (cnt == {1'b0, div_q}) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          cs_n_nxt  = 1'b1;
          set_done  = 1'b1;
          rx_load   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state != S_IDLE && !en_nxt) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      sclk_nxt  = 1'b0;
      cs_n_nxt  = 1'b1;
      set_done  = 1'b0;
      rx_load   = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      half   <= '0;
      div_q  <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      sclk   <= 1'b0;
      cs_n   <= 1'b1;
      en     <= 1'b0;
      ie     <= 1'b0;
      clkdiv <= '0;
      txdata <= '0;
      rxdata <= '0;
      done   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      half  <= half_nxt;
      div_q <= div_nxt;
      tx_sh <= tx_nxt;
      rx_sh <= rx_nxt;
      sclk  <= sclk_nxt;
      cs_n  <= cs_n_nxt;
      if (ctrl_wr) begin
        en     <= apb.pwdata[0];
        ie     <= apb.pwdata[2];
        clkdiv <= apb.pwdata[15:8];
      end
      if (tx_wr)   txdata <= apb.pwdata[SPI_W-1:0];
      if (rx_load) rxdata <= rx_sh;
      // hardware set beats a same-cycle software clear
      if (set_done)
        done <= 1'b1;
      else if (start_ok || (status_wr && apb.pwdata[1]))
        done <= 1'b0;
      irq <= done & ie;
    end
  end
endmodule
